// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: bundles every non-clock signal of the execute-issue
// stage.
//   in_*   : decode -> issue valid/ready handshake (instruction in)
//   alu_*  : issue -> ALU operands/control, ALU -> issue result/flags
//   out_*  : issue -> writeback/branch valid/ready handshake
//   slt_flag: sticky compare flag
// The slave modport is the issue stage itself. The master modport is the
// surrounding environment (decode, ALU, writeback).
interface alu_issue_ctrl_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned OPW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_opcode;
    logic [DW-1:0]  in_data1;
    logic [DW-1:0]  in_data2;
    logic [1:0]     in_rd;

    logic [2:0]     alu_ctrl;
    logic [DW-1:0]  alu_data1;
    logic [DW-1:0]  alu_data2;
    logic [DW-1:0]  alu_result;
    logic           alu_zero;
    logic           alu_slt;

    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_result;
    logic [1:0]     out_rd;
    logic           out_wr_en;
    logic           out_mem_rd;
    logic           out_mem_wr;
    logic           out_branch_taken;
    logic           out_illegal;
    logic           slt_flag;

    modport slave (
        input  in_valid, in_opcode, in_data1, in_data2, in_rd,
        input  alu_result, alu_zero, alu_slt,
        input  out_ready,
        output in_ready,
        output alu_ctrl, alu_data1, alu_data2,
        output out_valid, out_result, out_rd, out_wr_en, out_mem_rd,
        output out_mem_wr, out_branch_taken, out_illegal, slt_flag
    );

    modport master (
        output in_valid, in_opcode, in_data1, in_data2, in_rd,
        output alu_result, alu_zero, alu_slt,
        output out_ready,
        input  in_ready,
        input  alu_ctrl, alu_data1, alu_data2,
        input  out_valid, out_result, out_rd, out_wr_en, out_mem_rd,
        input  out_mem_wr, out_branch_taken, out_illegal, slt_flag
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-issue stage in front of the 8-bit ALU.
// This stage accepts a decoded instruction and registers its operands. It
// drives the ALU control code for one cycle, captures the combinational ALU
// result and flags, and then offers them to writeback. The writeback side
// can hold the result off with out_ready.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_issue_ctrl_if.slave (instruction in, ALU side, writeback out)
module alu_issue_ctrl #(
    parameter int unsigned DW  = 8,
    parameter int unsigned OPW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t     state;
    logic       accept;

    // Decoded attributes of the incoming opcode.
    logic [2:0] dec_ctrl;
    logic       dec_wr, dec_mrd, dec_mwr, dec_br, dec_cmp, dec_ill;

    // Attributes of the instruction in flight. They are applied when its
    // result is captured.
    logic [1:0] rd_q;
    logic       wr_q, mrd_q, mwr_q, br_q, cmp_q, ill_q;

    always_comb begin
        bus.in_ready = (state == IDLE) | ((state == WB) & bus.out_ready);
        accept       = bus.in_valid & bus.in_ready;
    end

    always_comb begin
        dec_ctrl = 3'b000;
        dec_wr   = 1'b0;
        dec_mrd  = 1'b0;
        dec_mwr  = 1'b0;
        dec_br   = 1'b0;
        dec_cmp  = 1'b0;
        dec_ill  = 1'b0;
        case (bus.in_opcode)
            OPW'(0), OPW'(1): begin dec_ctrl = 3'b001; dec_wr = 1'b1; end
            OPW'(2):          begin dec_ctrl = 3'b010; dec_wr = 1'b1; end
            OPW'(3):          begin dec_ctrl = 3'b011; dec_cmp = 1'b1; end
            OPW'(4):          begin dec_ctrl = 3'b100; dec_wr = 1'b1; end
            OPW'(5):          begin dec_ctrl = 3'b101; dec_wr = 1'b1; end
            OPW'(6):          begin dec_ctrl = 3'b110; dec_br = 1'b1; end
            OPW'(7): begin
                dec_ctrl = 3'b111;
                dec_mrd  = 1'b1;
                dec_wr   = 1'b1;
            end
            OPW'(8):          begin dec_ctrl = 3'b111; dec_mwr = 1'b1; end
            default:          dec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            rd_q                 <= '0;
            wr_q                 <= 1'b0;
            mrd_q                <= 1'b0;
            mwr_q                <= 1'b0;
            br_q                 <= 1'b0;
            cmp_q                <= 1'b0;
            ill_q                <= 1'b0;
            bus.alu_ctrl         <= '0;
            bus.alu_data1        <= '0;
            bus.alu_data2        <= '0;
            bus.out_valid        <= 1'b0;
            bus.out_result       <= '0;
            bus.out_rd           <= '0;
            bus.out_wr_en        <= 1'b0;
            bus.out_mem_rd       <= 1'b0;
            bus.out_mem_wr       <= 1'b0;
            bus.out_branch_taken <= 1'b0;
            bus.out_illegal      <= 1'b0;
            bus.slt_flag         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) state <= EXEC;
                end
                EXEC: begin
                    bus.out_valid        <= 1'b1;
                    bus.out_result       <= bus.alu_result;
                    bus.out_rd           <= rd_q;
                    bus.out_wr_en        <= wr_q;
                    bus.out_mem_rd       <= mrd_q;
                    bus.out_mem_wr       <= mwr_q;
                    bus.out_branch_taken <= br_q & bus.alu_zero;
                    bus.out_illegal      <= ill_q;
                    if (cmp_q) bus.slt_flag <= bus.alu_slt;
                    // Drop the control code once the result is captured, so
                    // that it already reads 000 if the next state is IDLE.
                    bus.alu_ctrl         <= '0;
                    state                <= WB;
                end
                WB: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= bus.in_valid ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // accept is only ever high in IDLE or WB, never in EXEC. This
            // write therefore cannot collide with the alu_ctrl clear above.
            if (accept) begin
                bus.alu_ctrl  <= dec_ctrl;
                bus.alu_data1 <= bus.in_data1;
                bus.alu_data2 <= bus.in_data2;
                rd_q          <= bus.in_rd;
                wr_q          <= dec_wr;
                mrd_q         <= dec_mrd;
                mwr_q         <= dec_mwr;
                br_q          <= dec_br;
                cmp_q         <= dec_cmp;
                ill_q         <= dec_ill;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl. It contains a
// behavioural ALU and a two-slot (execute / writeback) bundle model that
// predicts every output from the opcode table.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchecks = 0;
    int   nerrors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DW(8), .OPW(4)) bus ();

    alu_issue_ctrl #(.DW(8), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural ALU, keyed by the control code.
    logic [7:0] alu_r;
    always_comb begin
        alu_r = 8'h00;
        case (bus.alu_ctrl)
            3'b001, 3'b111: alu_r = bus.alu_data1 + bus.alu_data2;
            3'b010:         alu_r = ~(bus.alu_data1 & bus.alu_data2);
            3'b011, 3'b110: alu_r = bus.alu_data1 - bus.alu_data2;
            3'b100:         alu_r = bus.alu_data1 << bus.alu_data2[2:0];
            3'b101:         alu_r = bus.alu_data1 >> bus.alu_data2[2:0];
            default:        alu_r = 8'h00;
        endcase
        bus.alu_result = alu_r;
        bus.alu_zero   = (alu_r == 8'h00);
        bus.alu_slt    = ($signed(bus.alu_data1) < $signed(bus.alu_data2));
    end

    typedef struct {
        logic [2:0] ctrl;
        logic [7:0] d1, d2, res;
        logic [1:0] rd;
        logic       wr, mrd, mwr, br, ill, cmp, slt;
    } bundle_t;

    // Predicts what one instruction must produce, directly from the opcode
    // table and the arithmetic of each operation.
    function automatic bundle_t predict(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [1:0] rd);
        bundle_t p;
        p.d1 = a; p.d2 = b; p.rd = rd;
        p.wr = 0; p.mrd = 0; p.mwr = 0; p.br = 0; p.ill = 0; p.cmp = 0;
        p.slt = ($signed(a) < $signed(b));
        case (op)
            4'd0, 4'd1: begin p.ctrl = 3'd1; p.res = a + b; p.wr = 1; end
            4'd2: begin p.ctrl = 3'd2; p.res = ~(a & b); p.wr = 1; end
            4'd3: begin p.ctrl = 3'd3; p.res = a - b; p.cmp = 1; end
            4'd4: begin p.ctrl = 3'd4; p.res = a << b[2:0]; p.wr = 1; end
            4'd5: begin p.ctrl = 3'd5; p.res = a >> b[2:0]; p.wr = 1; end
            4'd6: begin p.ctrl = 3'd6; p.res = a - b; p.br = (a == b); end
            4'd7: begin p.ctrl = 3'd7; p.res = a + b; p.mrd = 1; p.wr = 1; end
            4'd8: begin p.ctrl = 3'd7; p.res = a + b; p.mwr = 1; end
            default: begin p.ctrl = 3'd0; p.res = 8'h00; p.ill = 1; end
        endcase
        return p;
    endfunction

    // Two-slot occupancy model: at most one bundle is executing and at most
    // one is waiting for writeback.
    bit      m_exec = 0, m_wb = 0, m_slt = 0;
    bundle_t m_eb, m_wbb;

    always @(posedge clk or negedge rst_n) begin
        bit ready, acc;
        if (!rst_n) begin
            m_exec = 0; m_wb = 0; m_slt = 0;
        end else begin
            ready = !m_exec && (!m_wb || bus.out_ready);
            acc   = ready && bus.in_valid;
            if (m_exec) begin
                m_wbb  = m_eb;
                m_wb   = 1;
                m_exec = 0;
                if (m_eb.cmp) m_slt = m_eb.slt;
            end else if (m_wb && bus.out_ready) begin
                m_wb = 0;
            end
            if (acc) begin
                m_eb   = predict(bus.in_opcode, bus.in_data1, bus.in_data2, bus.in_rd);
                m_exec = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("out_valid", 32'(bus.out_valid), 32'(m_wb));
        check("in_ready", 32'(bus.in_ready), 32'(!m_exec && (!m_wb || bus.out_ready)));
        check("slt_flag", 32'(bus.slt_flag), 32'(m_slt));
        if (m_wb) begin
            check("out_result", 32'(bus.out_result), 32'(m_wbb.res));
            check("out_rd", 32'(bus.out_rd), 32'(m_wbb.rd));
            check("out_wr_en", 32'(bus.out_wr_en), 32'(m_wbb.wr));
            check("out_mem_rd", 32'(bus.out_mem_rd), 32'(m_wbb.mrd));
            check("out_mem_wr", 32'(bus.out_mem_wr), 32'(m_wbb.mwr));
            check("out_branch", 32'(bus.out_branch_taken), 32'(m_wbb.br));
            check("out_illegal", 32'(bus.out_illegal), 32'(m_wbb.ill));
        end
        if (m_exec) begin
            check("alu_ctrl", 32'(bus.alu_ctrl), 32'(m_eb.ctrl));
            check("alu_data1", 32'(bus.alu_data1), 32'(m_eb.d1));
            check("alu_data2", 32'(bus.alu_data2), 32'(m_eb.d2));
        end else if (!m_wb) begin
            check("alu_ctrl_idle", 32'(bus.alu_ctrl), 32'd0);
        end
    endtask

    // Offer one instruction. Returns 2 time units after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] rd, input bit hold);
        bit ok = 0;
        bit r;
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_data1  = a;
        bus.in_data2  = b;
        bus.in_rd     = rd;
        while (!ok && n < 20) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            if (r) ok = 1;
            n++;
        end
        #2;
        if (!hold) bus.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_opcode = 4'd0;
        bus.in_data1  = 8'h00;
        bus.in_data2  = 8'h00;
        bus.in_rd     = 2'd0;
        bus.out_ready = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (rst_n) compare();
            end
            begin
                // Reset state
                tick(2);
                @(negedge clk);
                check("rst_out_valid", 32'(bus.out_valid), 32'd0);
                check("rst_in_ready", 32'(bus.in_ready), 32'd1);
                check("rst_out_result", 32'(bus.out_result), 32'd0);
                check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
                check("rst_alu_data1", 32'(bus.alu_data1), 32'd0);
                check("rst_slt", 32'(bus.slt_flag), 32'd0);
                @(posedge clk); #2;
                rst_n = 1'b1;
                tick(1);

                // add 7F+02, rd=2
                send(4'd0, 8'h7F, 8'h02, 2'd2, 0);
                @(negedge clk);
                check("add_exec_ctrl", 32'(bus.alu_ctrl), 32'd1);
                check("add_exec_valid", 32'(bus.out_valid), 32'd0);
                @(negedge clk);
                check("add_valid", 32'(bus.out_valid), 32'd1);
                check("add_result", 32'(bus.out_result), 32'h81);
                check("add_wr", 32'(bus.out_wr_en), 32'd1);
                check("add_rd", 32'(bus.out_rd), 32'd2);
                tick(1);

                // cmp 3 vs 9, then nand F0/3C
                send(4'd3, 8'h03, 8'h09, 2'd1, 0);
                tick(2);
                @(negedge clk);
                check("cmp_slt", 32'(bus.slt_flag), 32'd1);
                @(posedge clk); #2;
                send(4'd2, 8'hF0, 8'h3C, 2'd3, 0);
                @(negedge clk); @(negedge clk);
                check("nand_result", 32'(bus.out_result), 32'hCF);
                check("nand_slt_kept", 32'(bus.slt_flag), 32'd1);
                tick(1);

                // beq taken / not taken
                send(4'd6, 8'h05, 8'h05, 2'd0, 0);
                @(negedge clk); @(negedge clk);
                check("beq_taken", 32'(bus.out_branch_taken), 32'd1);
                check("beq_wr", 32'(bus.out_wr_en), 32'd0);
                tick(1);
                send(4'd6, 8'h05, 8'h06, 2'd0, 0);
                @(negedge clk); @(negedge clk);
                check("beq_not_taken", 32'(bus.out_branch_taken), 32'd0);
                tick(1);

                // Back-to-back lw then sw with in_valid held high
                send(4'd7, 8'h10, 8'h04, 2'd1, 1);
                bus.in_opcode = 4'd8;
                bus.in_data1  = 8'h20;
                bus.in_data2  = 8'h08;
                bus.in_rd     = 2'd2;
                @(negedge clk); @(negedge clk);
                check("lw_result", 32'(bus.out_result), 32'h14);
                check("lw_mem_rd", 32'(bus.out_mem_rd), 32'd1);
                check("lw_accept_in_wb", 32'(bus.in_ready), 32'd1);
                @(posedge clk); #2;
                bus.in_valid = 1'b0;
                @(negedge clk); @(negedge clk);
                check("sw_mem_wr", 32'(bus.out_mem_wr), 32'd1);
                check("sw_result", 32'(bus.out_result), 32'h28);
                tick(1);

                // Backpressure: sll held in WB for 5 cycles, new input ignored
                bus.out_ready = 1'b0;
                send(4'd4, 8'h03, 8'h02, 2'd1, 0);
                @(negedge clk); @(negedge clk);
                repeat (5) begin
                    @(posedge clk); #2;
                    bus.in_valid  = 1'b1;
                    bus.in_opcode = 4'd5;
                    bus.in_data1  = 8'h80;
                    bus.in_data2  = 8'h03;
                    @(negedge clk);
                    check("bp_result", 32'(bus.out_result), 32'h0C);
                    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                end
                @(posedge clk); #2;
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
                tick(1);
                @(negedge clk);
                check("bp_retired", 32'(bus.out_valid), 32'd0);
                @(posedge clk); #2;
                send(4'd5, 8'h80, 8'h03, 2'd3, 0);
                tick(2);

                // add wrap F0+20
                send(4'd1, 8'hF0, 8'h20, 2'd0, 0);
                tick(2);

                // Illegal opcode 1100
                send(4'd12, 8'hAA, 8'h55, 2'd1, 0);
                @(negedge clk);
                check("ill_ctrl", 32'(bus.alu_ctrl), 32'd0);
                @(negedge clk);
                check("ill_flag", 32'(bus.out_illegal), 32'd1);
                check("ill_side_effects",
                      32'({bus.out_wr_en, bus.out_mem_rd, bus.out_mem_wr, bus.out_branch_taken}),
                      32'd0);
                tick(1);

                // Reset in the middle of EXEC
                send(4'd3, 8'h02, 8'h09, 2'd0, 0);
                tick(2);
                send(4'd0, 8'h01, 8'h01, 2'd3, 0);
                #1 rst_n = 1'b0;
                #1;
                check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
                check("rst_mid_slt", 32'(bus.slt_flag), 32'd0);
                check("rst_mid_ctrl", 32'(bus.alu_ctrl), 32'd0);
                tick(2);
                rst_n = 1'b1;
                @(negedge clk);
                check("rst_rel_ready", 32'(bus.in_ready), 32'd1);
                repeat (3) @(negedge clk);
                check("rst_no_replay", 32'(bus.out_valid), 32'd0);
                tick(1);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
